// File: rtl/mul_sequencer.sv
// mul_sequencer: computes the low 32 bits of OpA * OpB by shift-and-add.
// The shared 32-bit ALU does the adds and the multiplicand shifts. The
// multiplier is shifted right locally. Registers only change in cycles
// where the arbiter grants the ALU.
module mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic        AluReq,
  input  logic        AluGnt,
  output logic [31:0] AluSrcA,
  output logic [31:0] AluSrcB,
  output logic [3:0]  AluControl,
  input  logic [31:0] AluResult
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_result;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic        w_fire;
  logic        w_zero_op;
  logic        w_mplier_last;
  logic [31:0] w_mplier_shr;

  // A new operation is only taken while idle; Start during Busy is dropped.
  assign w_accept      = (r_state == S_IDLE) && Start;
  // An ALU operation completes only when we request and are granted.
  assign w_fire        = AluReq && AluGnt;
  assign w_zero_op     = (OpA == 32'd0) || (OpB == 32'd0);
  // No multiplier bits remain above bit 0: the current ADD is the last one.
  assign w_mplier_last = (r_mplier[31:1] == 31'd0);
  assign w_mplier_shr  = {1'b0, r_mplier[31:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; ADD and SHIFT hold on a stalled (ungranted) cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (w_zero_op) begin
            w_state_next = S_DONE;
          end else if (OpB[0]) begin
            w_state_next = S_ADD;
          end else begin
            w_state_next = S_SHIFT;
          end
        end
      end
      S_ADD: begin
        if (w_fire) begin
          w_state_next = w_mplier_last ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // SHIFT is only entered with a set bit above bit 0, so this
        // always reaches ADD eventually.
        if (w_fire) begin
          w_state_next = w_mplier_shr[0] ? S_ADD : S_SHIFT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ALU request and operand/control drive, decoded from state and registers.
  always_comb begin
    AluReq     = 1'b0;
    AluSrcA    = 32'd0;
    AluSrcB    = 32'd0;
    AluControl = ALU_ADD;
    case (r_state)
      S_ADD: begin
        AluReq     = 1'b1;
        AluSrcA    = r_acc;
        AluSrcB    = r_mcand;
        AluControl = ALU_ADD;
      end
      S_SHIFT: begin
        AluReq     = 1'b1;
        AluSrcA    = r_mcand;
        AluSrcB    = 32'd1;
        AluControl = ALU_SLL;
      end
      default: begin
        AluReq     = 1'b0;
      end
    endcase
  end

  // Datapath registers: load on accept, update from the ALU on granted cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
    end else begin
      if (w_accept) begin
        r_acc    <= 32'd0;
        r_mcand  <= OpA;
        r_mplier <= OpB;
      end else if (w_fire && (r_state == S_ADD)) begin
        r_acc    <= AluResult;
      end else if (w_fire && (r_state == S_SHIFT)) begin
        r_mcand  <= AluResult;
        r_mplier <= w_mplier_shr;
      end
    end
  end

  // Registered status and result; Result captures the product on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= (w_state_next == S_DONE);
      if ((r_state == S_IDLE) && (w_state_next == S_DONE)) begin
        // Zero operand: the product is zero without touching the ALU.
        r_result <= 32'd0;
      end else if ((r_state == S_ADD) && (w_state_next == S_DONE)) begin
        // The final add's sum is the product; take it straight from the ALU.
        r_result <= AluResult;
      end
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: table of directed multiplies plus
// hand-written sequences for ALU sequencing, stalls, and mid-op events.
module tb_mul_sequencer;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        AluReq;
  logic        AluGnt;
  logic [31:0] AluSrcA;
  logic [31:0] AluSrcB;
  logic [3:0]  AluControl;
  logic [31:0] AluResult;

  int n_checks = 0;
  int n_fail   = 0;

  mul_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .OpA        (OpA),
    .OpB        (OpB),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .AluReq     (AluReq),
    .AluGnt     (AluGnt),
    .AluSrcA    (AluSrcA),
    .AluSrcB    (AluSrcB),
    .AluControl (AluControl),
    .AluResult  (AluResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shared ALU: ADD and SLL only.
  always_comb begin
    if (AluControl == 4'b0001) begin
      AluResult = AluSrcA << AluSrcB[4:0];
    end else begin
      AluResult = AluSrcA + AluSrcB;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          done_cyc;
  } vec_t;

  vec_t vecs[8];

  // Issue one multiply in the current cycle (called at a negedge) and
  // follow it through Done and the following idle cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int done_cyc);
    int cyc;
    Start = 1'b1;
    OpA   = a;
    OpB   = b;
    @(negedge clk);
    Start = 1'b0;
    OpA   = $urandom;
    OpB   = $urandom;
    cyc   = 1;
    check("busy_c1", {31'd0, Busy}, 32'd1);
    while (Done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, done_cyc);
    check("result", Result, res);
    check("busy_in_done", {31'd0, Busy}, 32'd1);
    $display("op %h * %h -> %h done in cycle %0d", a, b, Result, cyc);
    @(negedge clk);
    check("idle_done", {31'd0, Done}, 32'd0);
    check("idle_busy", {31'd0, Busy}, 32'd0);
    check("idle_result_held", Result, res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_ctrl [4];
    int cyc;

    vecs[0] = '{32'd3,        32'd5,        32'd15,        5};
    vecs[1] = '{32'd1,        32'h80000000, 32'h80000000,  33};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  64};
    vecs[3] = '{32'd7,        32'd0,        32'd0,         1};
    vecs[4] = '{32'd0,        32'd5,        32'd0,         1};
    vecs[5] = '{32'd7,        32'd3,        32'd21,        4};
    vecs[6] = '{32'd12345,    32'd100,      32'h0012D644,  10};
    vecs[7] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,  3};

    // Reset asserted together with Start: nothing may be accepted.
    reset  = 1'b1;
    Start  = 1'b1;
    OpA    = 32'd3;
    OpB    = 32'd5;
    AluGnt = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    Start = 1'b0;
    check("rst_busy",   {31'd0, Busy},   32'd0);
    check("rst_done",   {31'd0, Done},   32'd0);
    check("rst_result", Result,          32'd0);
    check("rst_req",    {31'd0, AluReq}, 32'd0);
    check("rst_srca",   AluSrcA,         32'd0);
    check("rst_srcb",   AluSrcB,         32'd0);
    check("rst_ctrl",   {28'd0, AluControl}, 32'd0);
    @(negedge clk);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);
    $display("reset with Start held: outputs cleared, no accept");

    // Table: back-to-back operations, each started in the idle cycle.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].done_cyc);
    end

    // ALU sequencing for 3 * 5: ADD, SHIFT, SHIFT, ADD.
    exp_ctrl[0] = 4'b0000;
    exp_ctrl[1] = 4'b0001;
    exp_ctrl[2] = 4'b0001;
    exp_ctrl[3] = 4'b0000;
    Start = 1'b1;
    OpA   = 32'd3;
    OpB   = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("seq_req",  {31'd0, AluReq}, 32'd1);
      check("seq_ctrl", {28'd0, AluControl}, {28'd0, exp_ctrl[c]});
      @(negedge clk);
    end
    check("seq_done",   {31'd0, Done},   32'd1);
    check("seq_result", Result,          32'd15);
    check("seq_req_done", {31'd0, AluReq}, 32'd0);
    $display("sequence 3*5: ctrl 0,1,1,0 then Done, Result %h", Result);
    @(negedge clk);

    // Stall: grant low in cycles 1-3 for 7 * 6.
    AluGnt = 1'b0;
    Start  = 1'b1;
    OpA    = 32'd7;
    OpB    = 32'd6;
    @(negedge clk);
    Start = 1'b0;
    cyc   = 1;
    for (int c = 1; c <= 3; c++) begin
      check("stall_req",  {31'd0, AluReq}, 32'd1);
      check("stall_srca", AluSrcA, 32'd7);
      check("stall_srcb", AluSrcB, 32'd1);
      check("stall_ctrl", {28'd0, AluControl}, 32'd1);
      if (c < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(posedge clk);
    #1 AluGnt = 1'b1;
    @(negedge clk);
    cyc++;
    while (Done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("stall_done_cycle", cyc, 8);
    check("stall_result", Result, 32'd42);
    $display("stall 7*6: done in cycle %0d, Result %h", cyc, Result);
    @(negedge clk);

    // Start during Busy is ignored.
    Start = 1'b1;
    OpA   = 32'd7;
    OpB   = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    cyc   = 1;
    @(negedge clk);
    cyc   = 2;
    Start = 1'b1;
    OpA   = 32'd2;
    OpB   = 32'd2;
    @(negedge clk);
    cyc   = 3;
    Start = 1'b0;
    while (Done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_done_cycle", cyc, 4);
    check("ign_result", Result, 32'd21);
    $display("start while busy ignored: done in cycle %0d, Result %h", cyc, Result);
    @(negedge clk);
    check("ign_idle_busy", {31'd0, Busy}, 32'd0);

    // Reset mid-operation aborts without Done.
    Start = 1'b1;
    OpA   = 32'd7;
    OpB   = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",   {31'd0, Busy},   32'd0);
    check("abort_done",   {31'd0, Done},   32'd0);
    check("abort_req",    {31'd0, AluReq}, 32'd0);
    check("abort_result", Result,          32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, Done}, 32'd0);
    end
    $display("reset mid-operation: aborted, Busy %0d Done %0d", Busy, Done);

    // A fresh operation after the abort works normally.
    run_op(32'd9, 32'd11, 32'd99, 1 + 3 + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle controller that computes RV32M `MUL` (the low 32 bits of OpA × OpB) by sequencing the shared 32-bit integer ALU through alternating add and shift-left-by-1 operations. It holds the accumulator, multiplicand and multiplier registers. It requests the ALU from the pipeline arbiter and advances only in granted cycles. It sits beside the execute stage, drives the ALU operand and control muxes while granted, and returns the product to the writeback path.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and 4-bit ALU control.

Ports:
- Clock and reset: one clock, `clk`; synchronous, active-high reset, `reset`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request a multiply; accepted only when `Busy`=0.
- `OpA`  in  32  multiplicand; sampled in the accept cycle.
- `OpB`  in  32  multiplier; sampled in the accept cycle.
- `Busy`  out  1  high from the cycle after accept through the `Done` cycle.
- `Done`  out  1  one-cycle pulse; `Result` is valid.
- `Result`  out  32  product low word; held until the next accept.
- `AluReq`  out  1  request for the shared ALU.
- `AluGnt`  in  1  grant; an operation completes only in a cycle with `AluReq`=1 and `AluGnt`=1.
- `AluSrcA`  out  32  operand A driven to the ALU.
- `AluSrcB`  out  32  operand B driven to the ALU.
- `AluControl`  out  4  ALU opcode: 4'b0000 is ADD, 4'b0001 is SLL.
- `AluResult`  in  32  combinational ALU result for the driven operands.

## Operation
- Internal registers:
  - Acc: 32-bit accumulator.
  - Mcand: 32-bit multiplicand, shifted left through the ALU.
  - Mplier: 32-bit multiplier, shifted right internally and never through the ALU.
- State IDLE:
  - `Busy`=0 and `AluReq`=0.
  - On `Start`, load Acc=0, Mcand=OpA, Mplier=OpB.
  - If OpA==0 or OpB==0, go to DONE with Acc=0.
  - Otherwise go to ADD if OpB[0]=1, else to SHIFT.
- State ADD:
  - Drive `AluReq`=1, `AluSrcA`=Acc, `AluSrcB`=Mcand, `AluControl`=4'b0000.
  - On grant, Acc←`AluResult`.
  - If Mplier[31:1]==0, go to DONE; otherwise go to SHIFT.
- State SHIFT:
  - Drive `AluReq`=1, `AluSrcA`=Mcand, `AluSrcB`=32'd1, `AluControl`=4'b0001.
  - On grant, Mcand←`AluResult` and Mplier←Mplier>>1.
  - Then go to ADD if the new Mplier[0]=1, else stay in SHIFT.
  - SHIFT is only entered when Mplier[31:1]≠0, so the sequence always terminates.
- State DONE:
  - `Done`=1, `Busy`=1, `Result`=Acc, `AluReq`=0.
  - Go to IDLE in the next cycle.
- Arithmetic rules:
  - All additions wrap modulo 2^32, matching the ALU adder.
  - The low word is identical for signed and unsigned operands, so no sign handling is needed.
- ALU drive outside ADD/SHIFT: `AluSrcA`=0, `AluSrcB`=0, `AluControl`=4'b0000.
- `Result` register:
  - Loaded when entering DONE.
  - Unchanged in IDLE.
  - Not updated by the accept cycle.
- Mid-operation behaviour:
  - `Start` while `Busy`=1 is ignored; no queueing.
  - `OpA` and `OpB` changes after accept have no effect.

## Timing
- Reset values, applied in the cycle after `reset` is sampled high:
  - State=IDLE.
  - `Busy`=0, `Done`=0, `Result`=0, `AluReq`=0.
  - `AluSrcA`=0, `AluSrcB`=0, `AluControl`=0.
  - Acc=0, Mcand=0, Mplier=0.
- Reset mid-operation aborts the operation: no `Done`, and `AluReq` drops the next cycle.
- Cycle counting, with accept in cycle 0 and a continuous grant:
  - Each ADD or SHIFT state occupies one cycle.
  - `Done` is high in cycle 1 + N_add + N_shift.
  - N_add = popcount(OpB).
  - N_shift = index of the highest set bit of OpB.
- Zero operand: `Done` in cycle 1.
- Worst case, OpB=0xFFFFFFFF: 32 ADD + 31 SHIFT cycles, `Done` in cycle 64.
- Stall (`AluGnt`=0 in ADD or SHIFT):
  - All registers and the state hold.
  - `AluReq`, `AluSrcA`, `AluSrcB` and `AluControl` stay stable.
  - Latency grows by one cycle per stalled cycle.
- Output registration:
  - `AluSrcA`, `AluSrcB` and `AluControl` are decoded combinationally from state and registers.
  - `AluResult` is consumed in the same cycle.
  - `Busy`, `Done` and `Result` are registered.
- Back-to-back operation: a new `Start` is accepted in the IDLE cycle immediately after DONE.
  - Minimum spacing between accepts is 2 cycles, for a zero operand.

## Test plan
- Reset with `Start`=1 → no accept that cycle; all outputs 0 the next cycle; a `Start` after deassertion is accepted normally.
- OpA=3, OpB=5, `AluGnt`=1 → sequence ADD, SHIFT, SHIFT, ADD in cycles 1–4; `Done` in cycle 5; `Result`=15; `AluControl` 0,1,1,0.
- OpA=1, OpB=0x80000000, full grant → 31 SHIFT cycles then 1 ADD; `Done` in cycle 33; `Result`=0x80000000.
- OpA=0xFFFFFFFF, OpB=0xFFFFFFFF, full grant → `Done` in cycle 64; `Result`=0x00000001 (wraparound).
- OpA=7, OpB=6, with `AluGnt` low in cycles 1–3 then high → ALU outputs stable while low; `Done` in cycle 8 instead of 5; `Result`=42.
- Mid-operation events, with OpA=7, OpB=3:
  - `Start` with OpA=2, OpB=2 at cycle 2 → ignored; `Result`=21.
  - Zero operand (OpB=0) → `Done` in cycle 1; `Result`=0.
  - `reset` at cycle 2 → no `Done`; `Busy`=0 the next cycle.
